// File: rtl/full_adder_1bit_pkg.sv
`timescale 10ps/1fs
// -----------------------------------------------------------------------------
// full_adder_1bit_pkg
// Shared constants for the gate-level cells of the ALU bit-slice.
//   GATE_DLY     : propagation delay of every gate primitive (5 x 10 ps = 50 ps)
//   slice_op_e   : meaning of the slice's 3-bit operation code as routed
//                  through mux8_1
//   slice_mux_inputs : packs the slice results into mux8_1's input vector
// -----------------------------------------------------------------------------
package full_adder_1bit_pkg;

    localparam int GATE_DLY = 5;

    // The operation code doubles as the mux8_1 select. Codes 2 and 3 both
    // route the adder sum; bit 0 of the code also drives the add/subtract
    // B-inversion mux, so 2 is add and 3 is subtract.
    typedef enum logic [2:0] {
        OP_PASS_B  = 3'd0,
        OP_ZERO_LO = 3'd1,
        OP_ADD     = 3'd2,
        OP_SUB     = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_XOR     = 3'd6,
        OP_ZERO_HI = 3'd7
    } slice_op_e;

    function automatic logic [7:0] slice_mux_inputs(
        input logic b,
        input logic sum,
        input logic a_and_b,
        input logic a_or_b,
        input logic a_xor_b
    );
        return {1'b0, a_xor_b, a_or_b, a_and_b, sum, sum, 1'b0, b};
    endfunction

endpackage

// File: rtl/mux2_1.sv
`timescale 10ps/1fs
// -----------------------------------------------------------------------------
// mux2_1
// Gate-level 2:1 multiplexer; out = in[sel]. Used by the slice to pick B or
// ~B and as the leaf cell of mux8_1.
// Ports:
//   in  [1:0] : data inputs, in[1] is selected when sel = 1
//   sel       : select
//   out       : selected data
// Delay: 3 gates from sel (through the inverter), 2 gates from data.
// -----------------------------------------------------------------------------
module mux2_1
    import full_adder_1bit_pkg::*;
(
    input  logic [1:0] in,
    input  logic       sel,
    output logic       out
);

    logic sel_n;
    logic pick_hi;
    logic pick_lo;

    not #(GATE_DLY) u_not_sel (sel_n, sel);
    and #(GATE_DLY) u_and_hi  (pick_hi, in[1], sel);
    and #(GATE_DLY) u_and_lo  (pick_lo, in[0], sel_n);
    or  #(GATE_DLY) u_or_out  (out, pick_hi, pick_lo);

endmodule

// File: rtl/mux8_1.sv
`timescale 10ps/1fs
// -----------------------------------------------------------------------------
// mux8_1
// 8:1 multiplexer built as a three-level binary tree of mux2_1 cells;
// out = in[sel]. Used for the final operation routing of the ALU slice.
// Ports:
//   in  [7:0] : data inputs
//   sel [2:0] : select; sel[0] steers the leaf level, sel[2] the root
//   out       : selected data
// -----------------------------------------------------------------------------
module mux8_1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    logic [3:0] stage1;
    logic [1:0] stage2;

    // Leaf level: adjacent input pairs, chosen by the LSB of the select.
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage1
        mux2_1 u_mux (
            .in  (in[2*gi+1 -: 2]),
            .sel (sel[0]),
            .out (stage1[gi])
        );
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_stage2
        mux2_1 u_mux (
            .in  (stage1[2*gi+1 -: 2]),
            .sel (sel[1]),
            .out (stage2[gi])
        );
    end

    mux2_1 u_stage3 (
        .in  (stage2),
        .sel (sel[2]),
        .out (out)
    );

endmodule

// File: rtl/full_adder_1bit.sv
`timescale 10ps/1fs
// -----------------------------------------------------------------------------
// full_adder_1bit
// Gate-level 1-bit full adder forming the arithmetic core of one ALU
// bit-slice, with registered copies of both results.
// Ports:
//   clk    : clock, rising edge updates out_q / Cout_q
//   reset  : synchronous, active-low; clears out_q and Cout_q only
//   a, b   : operand bits (b already inverted upstream for subtract)
//   Cin    : carry in
//   out    : combinational sum a ^ b ^ Cin
//   Cout   : combinational carry, majority(a, b, Cin)
//   out_q  : out registered on clk
//   Cout_q : Cout registered on clk
// Delay: sum 2 gates, carry 3 gates worst case (2 gates from Cin alone).
// -----------------------------------------------------------------------------
module full_adder_1bit
    import full_adder_1bit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic out,
    output logic Cout,
    output logic out_q,
    output logic Cout_q
);

    logic x;    // half-sum a ^ b, shared by sum and propagate paths
    logic g;    // generate
    logic p;    // propagate-and-carry

    xor #(GATE_DLY) u_xor_ab  (x, a, b);
    xor #(GATE_DLY) u_xor_sum (out, x, Cin);
    and #(GATE_DLY) u_and_g   (g, a, b);
    and #(GATE_DLY) u_and_p   (p, x, Cin);
    or  #(GATE_DLY) u_or_cout (Cout, g, p);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= 1'b0;
            Cout_q <= 1'b0;
        end else begin
            out_q  <= out;
            Cout_q <= Cout;
        end
    end

endmodule

// File: tb/tb_full_adder_1bit.sv
`timescale 10ps/1fs
module tb_full_adder_1bit;

    logic clk;
    logic reset;
    logic a, b, cin;
    logic out, cout, out_q, cout_q;

    logic [1:0] m2_in;
    logic       m2_sel;
    logic       m2_out;
    logic [7:0] m8_in;
    logic [2:0] m8_sel;
    logic       m8_out;

    logic sa, scin;
    logic s_out, s_cout, s_out_q, s_cout_q;

    int n_cmp  = 0;
    int n_fail = 0;

    full_adder_1bit u_dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .Cin    (cin),
        .out    (out),
        .Cout   (cout),
        .out_q  (out_q),
        .Cout_q (cout_q)
    );

    mux2_1 u_m2 (.in(m2_in), .sel(m2_sel), .out(m2_out));
    mux8_1 u_m8 (.in(m8_in), .sel(m8_sel), .out(m8_out));

    // Slice: operand B goes through the add/subtract mux before the adder.
    full_adder_1bit u_slice (
        .clk    (clk),
        .reset  (reset),
        .a      (sa),
        .b      (m2_out),
        .Cin    (scin),
        .out    (s_out),
        .Cout   (s_cout),
        .out_q  (s_out_q),
        .Cout_q (s_cout_q)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;   // 4 ns period

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] sum_tab;
        logic [7:0] carry_tab;
        logic [7:0] pat;
        int unsigned total;
        logic bv, sub;

        sum_tab   = 8'b1001_0110;
        carry_tab = 8'b1110_1000;

        reset = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
        m2_in = 2'b00; m2_sel = 1'b0; m8_in = 8'h00; m8_sel = 3'd0;
        sa = 1'b0; scin = 1'b0;

        // Reset state
        @(posedge clk); #1;
        check("reset_out_q", out_q, 1'b0);
        check("reset_cout_q", cout_q, 1'b0);

        // Exhaustive combinational truth table
        for (int i = 0; i < 8; i++) begin
            {a, b, cin} = 3'(i);
            #100;
            check($sformatf("sum_%0d", i), out, sum_tab[i]);
            check($sformatf("carry_%0d", i), cout, carry_tab[i]);
            $display("adder {a,b,cin}=%0d out=%b cout=%b", i, out, cout);
        end

        // Carry timing: generate then or = 2 gates = 100 ps after a rises
        a = 1'b0; b = 1'b1; cin = 1'b0;
        #100;
        a = 1'b1;
        #9;  check("cout_before_100ps", cout, 1'b0);
        #2;  check("cout_after_100ps", cout, 1'b1);
        #100; check("out_settled_0", out, 1'b0);
        $display("delay step a=1 b=1 cin=0 cout=%b out=%b", cout, out);

        // Register and reset
        @(negedge clk);
        reset = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b1;
        #100;
        check("comb_out_in_reset", out, 1'b1);
        check("comb_cout_in_reset", cout, 1'b1);
        @(posedge clk); #1;
        check("held_out_q", out_q, 1'b0);
        check("held_cout_q", cout_q, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("release_out_q", out_q, 1'b1);
        check("release_cout_q", cout_q, 1'b1);
        $display("reg release out_q=%b cout_q=%b", out_q, cout_q);

        // Random adder traffic with occasional reset
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 1'($urandom); b = 1'($urandom); cin = 1'($urandom);
            reset = ($urandom_range(0, 7) != 0);
            total = int'(a) + int'(b) + int'(cin);
            #100;
            check("rand_out", out, total[0]);
            check("rand_cout", cout, total[1]);
            @(posedge clk); #1;
            check("rand_out_q", out_q, reset ? total[0] : 1'b0);
            check("rand_cout_q", cout_q, reset ? total[1] : 1'b0);
            $display("rand a=%b b=%b cin=%b rst_n=%b out_q=%b cout_q=%b",
                     a, b, cin, reset, out_q, cout_q);
        end
        reset = 1'b1;

        // mux2_1 settles within ~150 ps of a select change
        m2_in = 2'b10; m2_sel = 1'b1;
        #100;
        m2_sel = 1'b0;
        #16; check("mux2_sel0", m2_out, 1'b0);
        m2_sel = 1'b1;
        #16; check("mux2_sel1", m2_out, 1'b1);
        $display("mux2 in=10 sel=1 out=%b", m2_out);

        // mux8_1 one-hot then fixed pattern
        m8_in = 8'b0010_0000;
        for (int s = 0; s < 8; s++) begin
            m8_sel = 3'(s);
            #100;
            check($sformatf("mux8_onehot_%0d", s), m8_out, (s == 5));
        end
        m8_in = 8'hA5;
        pat = 8'hA5;
        for (int s = 0; s < 8; s++) begin
            m8_sel = 3'(s);
            #100;
            check($sformatf("mux8_a5_%0d", s), m8_out, pat[s]);
            $display("mux8 in=a5 sel=%0d out=%b", s, m8_out);
        end
        for (int i = 0; i < 16; i++) begin
            pat = 8'($urandom);
            m8_in = pat;
            m8_sel = 3'($urandom_range(0, 7));
            #100;
            check("mux8_rand", m8_out, pat[m8_sel]);
        end

        // Slice subtract: 1 - 1 with carry-in 1 gives 0, no borrow
        sa = 1'b1; m2_in = {1'b0, 1'b1}; m2_sel = 1'b1; scin = 1'b1;
        #100;
        check("slice_sub_sum", s_out, 1'b0);
        check("slice_sub_cout", s_cout, 1'b1);
        $display("slice sub a=1 b=1 cin=1 sum=%b cout=%b", s_out, s_cout);

        for (int i = 0; i < 16; i++) begin
            logic sb;
            sa = 1'($urandom); sb = 1'($urandom); scin = 1'($urandom);
            sub = 1'($urandom);
            m2_in = {~sb, sb}; m2_sel = sub;
            bv = sub ? ~sb : sb;
            total = int'(sa) + int'(bv) + int'(scin);
            #100;
            check("slice_rand_sum", s_out, total[0]);
            check("slice_rand_cout", s_cout, total[1]);
            $display("slice a=%b b=%b sub=%b cin=%b sum=%b cout=%b",
                     sa, sb, sub, scin, s_out, s_cout);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
